// File: rtl/vram_access_scheduler.sv
// Arbitrates the SDRAM memory_controller between VDP slots, periodic refresh and an ext requester.
// Optional saturating statistics outputs are enabled by defining VRAM_SCHED_STATS_EN.
module vram_access_scheduler #(
    parameter int ADDR_W        = 22,
    parameter int REFRESH_IVL   = 400,
    parameter int EXT_ADDR_BASE = 0
) (
    input  logic              clk_w,
    input  logic              reset_n_w,
    input  logic              vdp_dlclk,
    input  logic              vdp_dhclk,
    input  logic              vdp_we_n,
    input  logic [16:0]       vdp_addr,
    input  logic [7:0]        vdp_wdata,
    output logic [15:0]       vdp_rdata,
    input  logic              ext_req,
    input  logic              ext_wr,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [15:0]       ext_wdata,
    input  logic [1:0]        ext_wmask,
    output logic              ext_ack,
    output logic [15:0]       ext_rdata,
    output logic              mc_read,
    output logic              mc_write,
    output logic              mc_refresh,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [15:0]       mc_din,
    output logic [1:0]        mc_wdm,
    input  logic              mc_busy,
`ifdef VRAM_SCHED_STATS_EN
    output logic [15:0]       stat_vdp_miss,
    output logic [15:0]       stat_ref_overrun,
    output logic [15:0]       stat_ext_grants,
`endif
    input  logic [15:0]       mc_dout
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_LAT, ST_WAIT} state_t;
    typedef enum logic [1:0] {SRC_VDP, SRC_REF, SRC_EXT} src_t;

    localparam int CNT_W = $clog2(REFRESH_IVL);
    localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_IVL - 1);

    state_t state, state_nxt;
    src_t   cmd_src;
    logic   cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [15:0] cmd_din;
    logic [1:0]  cmd_wdm;

    logic        slot_q, low_q, vdp_pend, ref_pend;
    logic        vdp_we_n_q;
    logic [16:0] vdp_addr_q;
    logic [7:0]  vdp_wdata_q;
    logic [CNT_W-1:0] ref_cnt;

    logic slot, low, slot_rise, low_rise, idle, ref_wrap;
    logic grant_vdp, grant_ref, grant_ext, fire, done;

    assign slot      = vdp_dlclk & vdp_dhclk;
    assign low       = ~vdp_dlclk & ~vdp_dhclk;
    assign slot_rise = slot & ~slot_q;
    assign low_rise  = low & ~low_q;
    assign idle      = (state == ST_IDLE);
    assign ref_wrap  = (ref_cnt == REF_LAST);

    // ext never starts inside a VDP slot; the ack cycle is excluded so a request
    // still held while its own ack is visible is not granted a second time.
    assign grant_vdp = idle & vdp_pend;
    assign grant_ref = idle & ~vdp_pend & ref_pend;
    assign grant_ext = idle & ~vdp_pend & ~ref_pend & ext_req & ~slot & ~ext_ack;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        fire      = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_IDLE:  if (grant_vdp | grant_ref | grant_ext) state_nxt = ST_ISSUE;
            ST_ISSUE: if (!mc_busy) begin
                fire      = 1'b1;
                state_nxt = ST_LAT;
            end
            ST_LAT:   state_nxt = ST_WAIT;
            ST_WAIT:  if (!mc_busy) begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign mc_read    = fire & (cmd_src != SRC_REF) & ~cmd_wr;
    assign mc_write   = fire & (cmd_src != SRC_REF) & cmd_wr;
    assign mc_refresh = fire & (cmd_src == SRC_REF);
    assign mc_addr    = cmd_addr;
    assign mc_din     = cmd_din;
    assign mc_wdm     = cmd_wdm;

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            state       <= ST_IDLE;
            slot_q      <= 1'b0;
            low_q       <= 1'b0;
            vdp_pend    <= 1'b0;
            ref_pend    <= 1'b0;
            ref_cnt     <= '0;
            vdp_we_n_q  <= 1'b1;
            vdp_addr_q  <= '0;
            vdp_wdata_q <= '0;
            cmd_src     <= SRC_VDP;
            cmd_wr      <= 1'b0;
            cmd_addr    <= '0;
            cmd_din     <= '0;
            cmd_wdm     <= '0;
            vdp_rdata   <= '0;
            ext_rdata   <= '0;
            ext_ack     <= 1'b0;
        end else begin
            state    <= state_nxt;
            slot_q   <= slot;
            low_q    <= low;
            ref_cnt  <= ref_wrap ? '0 : ref_cnt + 1'b1;
            vdp_pend <= slot_rise | (vdp_pend & ~grant_vdp);
            ref_pend <= ref_wrap | (low_rise & idle) | (ref_pend & ~grant_ref);
            ext_ack  <= done & (cmd_src == SRC_EXT);

            // A new slot overwrites an unserved one; a same-cycle grant already took the old copy.
            if (slot_rise) begin
                vdp_we_n_q  <= vdp_we_n;
                vdp_addr_q  <= vdp_addr;
                vdp_wdata_q <= vdp_wdata;
            end

            if (grant_vdp) begin
                cmd_src  <= SRC_VDP;
                cmd_wr   <= ~vdp_we_n_q;
                cmd_addr <= {{(ADDR_W-16){1'b0}}, vdp_addr_q[15:0]};
                cmd_din  <= {vdp_wdata_q, vdp_wdata_q};
                cmd_wdm  <= {~vdp_addr_q[16], vdp_addr_q[16]};
            end else if (grant_ref) begin
                cmd_src  <= SRC_REF;
                cmd_wr   <= 1'b0;
                cmd_addr <= '0;
                cmd_din  <= '0;
                cmd_wdm  <= '0;
            end else if (grant_ext) begin
                cmd_src  <= SRC_EXT;
                cmd_wr   <= ext_wr;
                cmd_addr <= ext_addr + ADDR_W'(EXT_ADDR_BASE);
                cmd_din  <= ext_wdata;
                cmd_wdm  <= ext_wmask;
            end

            if (done && !cmd_wr && cmd_src == SRC_VDP) vdp_rdata <= mc_dout;
            if (done && !cmd_wr && cmd_src == SRC_EXT) ext_rdata <= mc_dout;
        end
    end

`ifdef VRAM_SCHED_STATS_EN
    logic ev_vdp_miss, ev_ref_overrun;

    assign ev_vdp_miss    = slot_rise & vdp_pend & ~grant_vdp;
    assign ev_ref_overrun = ref_wrap & ref_pend & ~grant_ref;

    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            stat_vdp_miss    <= '0;
            stat_ref_overrun <= '0;
            stat_ext_grants  <= '0;
        end else begin
            if (ev_vdp_miss && stat_vdp_miss != 16'hFFFF) stat_vdp_miss <= stat_vdp_miss + 1'b1;
            if (ev_ref_overrun && stat_ref_overrun != 16'hFFFF) stat_ref_overrun <= stat_ref_overrun + 1'b1;
            if (grant_ext && stat_ext_grants != 16'hFFFF) stat_ext_grants <= stat_ext_grants + 1'b1;
        end
    end
`endif

endmodule
